fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS pipeline; sits directly upstream of the ID-stage field decoder.
- Owns the PC and computes the next PC from redirect requests issued by ID: sequential, branch, j/jal, jr.
- Drives the external combinational instruction memory and registers the fetched word, its PC and its link address for ID.
- Uses one architectural delay slot and flags misaligned or out-of-range fetch addresses.

---
 rtl/fetch_stage.sv | 135 +++++++++++++
 tb/tb_fetch_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register.
// Owns the fetch PC, selects the next PC from ID redirects (one delay slot),
// drives a combinational instruction memory and registers the fetched word
// together with its PC, its link address and an address-error flag.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter int unsigned IMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  npc_sel,
  input  logic [15:0] br_offset,
  input  logic [25:0] j_index,
  input  logic [31:0] jr_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic        valid_d,
  output logic        adel_d
);

  localparam logic [31:0] WinBytes = 32'(IMEM_WORDS * 4);

  typedef enum logic [1:0] {
    NpcSeq    = 2'b00,
    NpcBranch = 2'b01,
    NpcJump   = 2'b10,
    NpcJr     = 2'b11
  } npc_sel_e;

  logic [31:0] pc_q, pc_d_next;

  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc8_q, ifid_pc8_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        ifid_adel_q, ifid_adel_d;

  logic [31:0] pc_plus4;
  logic [31:0] br_target;
  logic [31:0] jump_target;
  logic [31:0] pc_off;
  logic        in_window;
  logic        fetch_err;
  logic        redirect_en;

  // Fetch address classification and candidate targets.
  always_comb begin
    pc_plus4    = pc_q + 32'd4;
    br_target   = pc_q + {{14{br_offset[15]}}, br_offset, 2'b00};
    jump_target = {pc_q[31:28], j_index, 2'b00};
    pc_off      = pc_q - RESET_PC;
    in_window   = (pc_q >= RESET_PC) && (pc_off < WinBytes);
    fetch_err   = (pc_q[1:0] != 2'b00) || !in_window;
    // A redirect is only trusted when ID actually holds an instruction and is not held.
    redirect_en = ifid_valid_q && !stall;
  end

  // Next-PC selection; the current pc_q is the delay-slot address.
  always_comb begin
    pc_d_next = pc_plus4;
    if (redirect_en) begin
      unique case (npc_sel_e'(npc_sel))
        NpcSeq:    pc_d_next = pc_plus4;
        NpcBranch: pc_d_next = br_target;
        NpcJump:   pc_d_next = jump_target;
        NpcJr:     pc_d_next = jr_target;
        default:   pc_d_next = pc_plus4;
      endcase
    end
  end

  // IF/ID next-state: flush beats stall, stall holds, otherwise capture the fetch.
  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc8_d   = ifid_pc8_q;
    ifid_valid_d = ifid_valid_q;
    ifid_adel_d  = ifid_adel_q;
    if (flush) begin
      ifid_instr_d = 32'd0;
      ifid_pc_d    = 32'd0;
      ifid_pc8_d   = 32'd0;
      ifid_valid_d = 1'b0;
      ifid_adel_d  = 1'b0;
    end else if (!stall) begin
      // A faulting fetch is delivered as a valid nop so the exception reaches ID.
      ifid_instr_d = fetch_err ? 32'd0 : imem_rdata;
      ifid_pc_d    = pc_q;
      ifid_pc8_d   = pc_q + 32'd8;
      ifid_valid_d = 1'b1;
      ifid_adel_d  = fetch_err;
    end
  end

  // PC register; held while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (!stall) begin
      pc_q <= pc_d_next;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_instr_q <= 32'd0;
      ifid_pc_q    <= 32'd0;
      ifid_pc8_q   <= 32'd0;
      ifid_valid_q <= 1'b0;
      ifid_adel_q  <= 1'b0;
    end else begin
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc8_q   <= ifid_pc8_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_adel_q  <= ifid_adel_d;
    end
  end

  assign imem_addr = pc_q;
  assign pc_f      = pc_q;
  assign instr_d   = ifid_instr_q;
  assign pc_d      = ifid_pc_q;
  assign pc8_d     = ifid_pc8_q;
  assign valid_d   = ifid_valid_q;
  assign adel_d    = ifid_adel_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomised plus directed bench for fetch_stage: a driver issues one cycle of
// stimulus, steps an architectural model and queues the expected outputs; a
// monitor pops one entry per clock and compares it with the DUT.
module tb_fetch_stage;

  localparam logic [31:0] Base  = 32'h0000_3000;
  localparam int unsigned Words = 1024;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic [1:0]  npc_sel;
  logic [15:0] br_offset;
  logic [25:0] j_index;
  logic [31:0] jr_target;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] pc_f, instr_d, pc_d, pc8_d;
  logic        valid_d, adel_d;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [Words];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcd;
    logic [31:0] pc8;
    logic        valid;
    logic        adel;
  } exp_t;

  exp_t exp_q[$];

  // Architectural model state.
  logic [31:0] m_pc, m_instr, m_pcd, m_pc8;
  logic        m_valid, m_adel;

  fetch_stage #(
    .RESET_PC  (Base),
    .IMEM_WORDS(Words)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .flush     (flush),
    .npc_sel   (npc_sel),
    .br_offset (br_offset),
    .j_index   (j_index),
    .jr_target (jr_target),
    .imem_addr (imem_addr),
    .imem_rdata(imem_rdata),
    .pc_f      (pc_f),
    .instr_d   (instr_d),
    .pc_d      (pc_d),
    .pc8_d     (pc8_d),
    .valid_d   (valid_d),
    .adel_d    (adel_d)
  );

  always #5 clk = ~clk;

  function automatic bit bad_addr(input logic [31:0] a);
    longint unsigned ua = longint'(a);
    return (a % 4 != 0) || (ua < longint'(Base)) || (ua >= longint'(Base) + 4 * Words);
  endfunction

  // Combinational memory; out-of-window reads return junk the DUT must not forward.
  always_comb begin
    imem_rdata = 32'hDEAD_BEEF;
    if (!bad_addr(imem_addr)) imem_rdata = mem[(imem_addr - Base) / 4];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Step the model for one clock with the currently driven inputs.
  task automatic model_step();
    logic [31:0] nxt, fetched;
    bit          fault;
    int          soff;
    if (reset) begin
      m_pc = Base; m_instr = 0; m_pcd = 0; m_pc8 = 0; m_valid = 0; m_adel = 0;
      return;
    end
    fault   = bad_addr(m_pc);
    fetched = fault ? 32'd0 : mem[(m_pc - Base) / 4];
    nxt     = m_pc + 4;
    if (m_valid && !stall) begin
      case (npc_sel)
        2'd1: begin
          soff = int'($signed(br_offset));
          nxt  = m_pc + 32'(soff * 4);
        end
        2'd2: nxt = (m_pc & 32'hF000_0000) | (32'(j_index) * 4);
        2'd3: nxt = jr_target;
        default: nxt = m_pc + 4;
      endcase
    end
    if (flush) begin
      m_instr = 0; m_pcd = 0; m_pc8 = 0; m_valid = 0; m_adel = 0;
    end else if (!stall) begin
      m_instr = fetched; m_pcd = m_pc; m_pc8 = m_pc + 8; m_valid = 1; m_adel = fault;
    end
    if (!stall) m_pc = nxt;
  endtask

  // Drive one cycle at the falling edge, queue the expectation, return after the
  // rising edge once the monitor has sampled.
  task automatic cyc(input bit rst, input bit stl, input bit fl, input logic [1:0] sel,
                     input logic [15:0] off, input logic [25:0] jidx, input logic [31:0] jrt);
    exp_t e;
    @(negedge clk);
    reset = rst; stall = stl; flush = fl; npc_sel = sel;
    br_offset = off; j_index = jidx; jr_target = jrt;
    model_step();
    e.pc = m_pc; e.instr = m_instr; e.pcd = m_pcd; e.pc8 = m_pc8;
    e.valid = m_valid; e.adel = m_adel;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic seq();
    cyc(0, 0, 0, 2'd0, 16'd0, 26'd0, 32'd0);
  endtask

  // Monitor: every clock the DUT presents a new pipeline state.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pc_f", pc_f, e.pc);
      chk("imem_addr", imem_addr, e.pc);
      chk("instr_d", instr_d, e.instr);
      chk("pc_d", pc_d, e.pcd);
      chk("pc8_d", pc8_d, e.pc8);
      chk("valid_d", 32'(valid_d), 32'(e.valid));
      chk("adel_d", 32'(adel_d), 32'(e.adel));
    end
  end

  initial begin
    logic [31:0] rt;
    logic [25:0] ji;
    logic [15:0] bo;
    for (int i = 0; i < int'(Words); i++) mem[i] = $urandom;
    mem[0] = 32'h3C01_0001;
    mem[1] = 32'h3421_0002;
    mem[2] = 32'h0000_0000;
    reset = 1; stall = 0; flush = 0; npc_sel = 0; br_offset = 0; j_index = 0; jr_target = 0;
    m_pc = 0; m_instr = 0; m_pcd = 0; m_pc8 = 0; m_valid = 0; m_adel = 0;

    // Reset state.
    cyc(1, 0, 0, 2'd0, 16'd0, 26'd0, 32'd0);
    chk("rst_pc_f", pc_f, 32'h3000);
    chk("rst_valid", 32'(valid_d), 32'd0);
    chk("rst_instr", instr_d, 32'd0);

    // Sequential fetch.
    seq();
    chk("seq1_instr", instr_d, 32'h3C01_0001);
    chk("seq1_pc_d", pc_d, 32'h3000);
    chk("seq1_pc8", pc8_d, 32'h3008);
    seq();
    chk("seq2_instr", instr_d, 32'h3421_0002);
    chk("seq2_pc_d", pc_d, 32'h3004);
    chk("seq2_pc8", pc8_d, 32'h300C);
    chk("seq2_pc_f", pc_f, 32'h3008);

    // Taken branch back by two words; delay slot at 0x3008 captured.
    cyc(0, 0, 0, 2'd1, 16'hFFFE, 26'd0, 32'd0);
    chk("br_pc_f", pc_f, 32'h3000);
    chk("br_slot_pc_d", pc_d, 32'h3008);
    chk("br_slot_valid", 32'(valid_d), 32'd1);

    // Position at 0x3010, then jump.
    cyc(0, 0, 0, 2'd3, 16'd0, 26'd0, 32'h3010);
    chk("jr_pc_f", pc_f, 32'h3010);
    cyc(0, 0, 0, 2'd2, 16'd0, 26'h000_0C10, 32'd0);
    chk("j_pc_f", pc_f, 32'h3040);

    // Same jump with a bubble in ID is ignored.
    cyc(0, 0, 1, 2'd3, 16'd0, 26'd0, 32'h3010);
    chk("jrfl_pc_f", pc_f, 32'h3010);
    chk("jrfl_valid", 32'(valid_d), 32'd0);
    cyc(0, 0, 0, 2'd2, 16'd0, 26'h000_0C10, 32'd0);
    chk("jinv_pc_f", pc_f, 32'h3014);

    // Misaligned jr target.
    cyc(0, 0, 0, 2'd3, 16'd0, 26'd0, 32'h3002);
    chk("jrmis_pc_f", pc_f, 32'h3002);
    seq();
    chk("mis_adel", 32'(adel_d), 32'd1);
    chk("mis_instr", instr_d, 32'd0);
    chk("mis_pc_d", pc_d, 32'h3002);
    chk("mis_valid", 32'(valid_d), 32'd1);

    // Out-of-window jr target.
    cyc(0, 0, 0, 2'd3, 16'd0, 26'd0, 32'h5000);
    seq();
    chk("oow_adel", 32'(adel_d), 32'd1);
    chk("oow_pc_d", pc_d, 32'h5000);

    // Stall two cycles, then flush alone, then stall with flush.
    cyc(0, 1, 0, 2'd2, 16'd0, 26'h3FF_FFFF, 32'd0);
    cyc(0, 1, 0, 2'd0, 16'd0, 26'd0, 32'd0);
    chk("stall_pc_f", pc_f, 32'h5004);
    chk("stall_pc_d", pc_d, 32'h5000);
    cyc(0, 0, 1, 2'd0, 16'd0, 26'd0, 32'd0);
    chk("flush_pc_f", pc_f, 32'h5008);
    chk("flush_valid", 32'(valid_d), 32'd0);
    seq();
    cyc(0, 1, 1, 2'd0, 16'd0, 26'd0, 32'd0);
    chk("stfl_pc_f", pc_f, 32'h500C);
    chk("stfl_valid", 32'(valid_d), 32'd0);

    // Reset during a stalled jump.
    cyc(0, 0, 0, 2'd3, 16'd0, 26'd0, 32'h3100);
    cyc(1, 1, 0, 2'd2, 16'd0, 26'h000_0C10, 32'd0);
    chk("rst2_pc_f", pc_f, 32'h3000);
    chk("rst2_valid", 32'(valid_d), 32'd0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      rt = ($urandom_range(0, 7) == 0) ? $urandom : Base + 32'($urandom_range(0, Words - 1)) * 4;
      ji = ($urandom_range(0, 7) == 0) ? 26'($urandom)
                                      : 26'((Base + 32'($urandom_range(0, Words - 1)) * 4) >> 2);
      bo = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 64) - 32);
      cyc($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
          2'($urandom), bo, ji, rt);
    end

    @(posedge clk);
    #3;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
